pattern_predictor_bank: RTL
===========================

Name: pattern_predictor_bank

Overview:
Parametrised successor to the fixed-encoding 1-bit pattern predictors. It predicts the next sample of a serial bit stream using a selectable scheme: a single saturating counter, a history-indexed table of saturating counters, last-value, or static. It scores each prediction against the actual sample and keeps saturating sample and match statistics. It sits beside the existing predictors in the pattern-prediction lab datapath, fed one bit per accepted cycle.

Parameters:
CW, 2, saturating counter width in bits (legal 1..4).
HW, 2, history length in bits; the table has 2^HW entries (legal 0..4; 0 means a single entry and no history register).
CNT_W, 8, width of the statistics counters.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  input  1  X is a valid sample this cycle.
X  input  1  current pattern sample.
mode  input  2  0 = BIMODAL, 1 = LOCAL, 2 = LASTVAL, 3 = STATIC1.
clear_stats  input  1  synchronous clear of the statistics counters.
pred  output  1  combinational prediction for the current X.
Y  output  1  registered prediction of the last accepted sample.
Y_match  output  1  registered result of pred == X for the last accepted sample.
out_valid  output  1  Y and Y_match were updated this cycle.
X_cnt  output  CNT_W  accepted samples since reset or clear.
match_cnt  output  CNT_W  correct predictions since reset or clear.

Behaviour:
- Reset (reset == 0, asynchronous assert, synchronous release):
  - all table counters = 2^(CW-1) (weak predict-1);
  - hist = 0; last_x = 1;
  - Y = 0, Y_match = 0, out_valid = 0, X_cnt = 0, match_cnt = 0.
- Index selection:
  - mode 1: idx = hist.
  - all other modes: idx = 0.
- pred, combinational from current state and mode:
  - modes 0 and 1: MSB of table[idx].
  - mode 2: last_x.
  - mode 3: 1.
  - A mode change takes effect in the same cycle.
- On each rising clk edge with in_valid == 1:
  - Table update, in every mode so the table stays trained: table[idx] increments if X == 1 and it is not at 2^CW-1; decrements if X == 0 and it is not at 0. It never wraps.
  - Only the entry selected by the current mode's idx is updated.
  - hist <= {hist[HW-2:0], X} (for HW == 1, hist <= X); last_x <= X.
  - Y <= pred; Y_match <= (pred == X); out_valid <= 1. Latency is 1 cycle from sample to scored output.
- With in_valid == 0: table, hist, last_x, Y, Y_match, X_cnt and match_cnt all hold; out_valid <= 0.
- Statistics:
  - X_cnt increments per accepted sample and saturates at 2^CNT_W-1.
  - match_cnt increments when pred == X on an accepted sample and saturates likewise.
  - The saturation check is independent per counter.
- clear_stats == 1:
  - X_cnt and match_cnt are cleared; predictor state is untouched.
  - If in_valid is also 1 in that cycle, the current sample counts: X_cnt <= 1 and match_cnt <= (pred == X).
- X is sampled only on clk edges; it has no effect on registered state between edges.
- mode == 3 still trains the table and hist.

Test Plan:
1. Reset: assert reset = 0 mid-stream with in_valid high -> outputs immediately at reset values. After release, pred = 1, X_cnt = 0, match_cnt = 0; table entries read 2 (CW = 2).
2. BIMODAL (mode 0, CW = 2): X = 0,0,0,1 on consecutive valid cycles -> pred = 1,0,0,0; Y_match = 0,1,1,0 one cycle later; final X_cnt = 4, match_cnt = 2; table[0] = 1.
3. LOCAL (mode 1, HW = 2): alternating 0,1 for 16 samples -> samples 9..16 all match; match_cnt rises by exactly 8 over them. BIMODAL on the same stream matches at most 50 %.
4. LASTVAL (mode 2): X = 1,1,0,0 -> pred = 1,1,1,0; Y_match = 1,1,0,1.
5. Saturation (CNT_W = 8): 300 valid samples of X = 1 in mode 0 -> X_cnt = 255, match_cnt = 255, both held; table[0] stays 3. Insert in_valid = 0 gaps -> counters and out_valid = 0 hold.
6. clear_stats together with in_valid, matching sample -> next cycle X_cnt = 1, match_cnt = 1, prediction unchanged. clear_stats alone -> X_cnt = 0, match_cnt = 0.

Source files
------------

// File: rtl/pattern_predictor_bank.sv
// Bit-stream predictor bank: bimodal / history-indexed / last-value / static prediction
// with per-sample scoring and saturating sample and match statistics.
module pattern_predictor_bank #(
  parameter int unsigned CW    = 2,
  parameter int unsigned HW    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             X,
  input  logic [1:0]       mode,
  input  logic             clear_stats,
  output logic             pred,
  output logic             Y,
  output logic             Y_match,
  output logic             out_valid,
  output logic [CNT_W-1:0] X_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    MODE_BIMODAL = 2'd0,
    MODE_LOCAL   = 2'd1,
    MODE_LASTVAL = 2'd2,
    MODE_STATIC1 = 2'd3
  } mode_e;

  localparam int unsigned   ENTRIES  = 1 << HW;
  localparam int unsigned   IW       = (HW == 0) ? 1 : HW;
  localparam logic [CW-1:0] CTR_INIT = CW'(1 << (CW - 1));

  mode_e         mode_sel;
  logic [CW-1:0] tab_q [ENTRIES];
  logic [IW-1:0] hist_idx;
  logic [IW-1:0] idx;
  logic [CW-1:0] entry;
  logic [CW-1:0] entry_next;
  logic          last_x_q;
  logic          hit;

  assign mode_sel = mode_e'(mode);

  generate
    if (HW == 0) begin : g_no_hist
      assign hist_idx = '0;
    end else begin : g_hist
      logic [HW-1:0] hist_q;
      logic [HW-1:0] hist_next;

      if (HW == 1) begin : g_h1
        assign hist_next = X;
      end else begin : g_hn
        assign hist_next = {hist_q[HW-2:0], X};
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hist_q <= '0;
        end else if (in_valid) begin
          hist_q <= hist_next;
        end
      end

      assign hist_idx = hist_q;
    end
  endgenerate

  always_comb begin
    idx = '0;
    if (mode_sel == MODE_LOCAL) begin
      idx = hist_idx;
    end
  end

  // Mux by compare so a single-entry table needs no special-cased index width.
  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (idx == IW'(i)) begin
        entry = tab_q[i];
      end
    end
  end

  always_comb begin
    entry_next = entry;
    if (X && (entry != '1)) begin
      entry_next = entry + CW'(1);
    end else if (!X && (entry != '0)) begin
      entry_next = entry - CW'(1);
    end
  end

  always_comb begin
    pred = 1'b1;
    unique case (mode_sel)
      MODE_BIMODAL, MODE_LOCAL: pred = entry[CW-1];
      MODE_LASTVAL:             pred = last_x_q;
      MODE_STATIC1:             pred = 1'b1;
      default:                  pred = 1'b1;
    endcase
  end

  assign hit = (pred == X);

  // Table trains in every mode so switching schemes starts from a warm state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tab_q[i] <= CTR_INIT;
      end
    end else if (in_valid) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (idx == IW'(i)) begin
          tab_q[i] <= entry_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_x_q  <= 1'b1;
      Y         <= 1'b0;
      Y_match   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        last_x_q <= X;
        Y        <= pred;
        Y_match  <= hit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      X_cnt     <= '0;
      match_cnt <= '0;
    end else if (clear_stats) begin
      X_cnt     <= in_valid ? CNT_W'(1) : '0;
      match_cnt <= (in_valid && hit) ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      if (X_cnt != '1) begin
        X_cnt <= X_cnt + CNT_W'(1);
      end
      if (hit && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
